// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the two-requester SRAM arbiter.
// Holds requester indices and the in-flight read tag encoding.
package sram_arbiter_pkg;

    localparam int unsigned REQ_INST = 0;
    localparam int unsigned REQ_DATA = 1;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_M0   = 2'b01,
        TAG_M1   = 2'b10
    } tag_e;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way arbitration decision, combinational.
// Ports: req_i[1:0] requests, last_gnt_i last winner index,
//        gnt_o[1:0] one-hot grant (zero when no request).
module rr_arb2
    import sram_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_i[REQ_INST] && req_i[REQ_DATA]) begin
            // Contested: data wins in fixed mode, otherwise
            // whoever did not win last time.
            if (FIXED_PRIO || (last_gnt_i == 1'b0)) begin
                gnt_o[REQ_DATA] = 1'b1;
            end else begin
                gnt_o[REQ_INST] = 1'b1;
            end
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between an instruction (m0) and a data
// (m1) requester with a same-cycle grant and 1-cycle read return.
// Ports: clk/reset (sync, active high); mN_req/we/addr/wdata in,
//        mN_gnt/rvalid/rdata out; ram_en/we/addr/wdata out, ram_rdata in.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       last_gnt_q;
    logic       last_gnt_d;
    tag_e       tag_q;
    tag_e       tag_d;
    logic       unused_addr;

    // Byte offset and bits above the RAM size wrap away.
    assign unused_addr = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                           m1_addr[31:ADDR_W+2], m1_addr[1:0]};

    // No access may be issued while reset is held.
    assign req = {m1_req, m0_req} & {2{~reset}};

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_arb (
        .req_i      (req),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt)
    );

    assign m0_gnt = gnt[REQ_INST];
    assign m1_gnt = gnt[REQ_DATA];

    always_comb begin
        ram_en     = 1'b0;
        ram_we     = 4'b0000;
        ram_addr   = '0;
        ram_wdata  = '0;
        tag_d      = TAG_NONE;
        last_gnt_d = last_gnt_q;
        unique case (1'b1)
            gnt[REQ_DATA]: begin
                ram_en     = 1'b1;
                ram_we     = m1_we;
                ram_addr   = m1_addr[ADDR_W+1:2];
                ram_wdata  = m1_wdata;
                last_gnt_d = 1'b1;
                if (m1_we == 4'b0000) tag_d = TAG_M1;
            end
            gnt[REQ_INST]: begin
                ram_en     = 1'b1;
                ram_we     = m0_we;
                ram_addr   = m0_addr[ADDR_W+1:2];
                ram_wdata  = m0_wdata;
                last_gnt_d = 1'b0;
                if (m0_we == 4'b0000) tag_d = TAG_M0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q      <= TAG_NONE;
            last_gnt_q <= 1'b1;
        end else begin
            tag_q      <= tag_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // A tag left over from the edge before reset rose must not
    // surface while reset is held.
    assign m0_rvalid = (tag_q == TAG_M0) && !reset;
    assign m1_rvalid = (tag_q == TAG_M1) && !reset;
    assign m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: round-robin and fixed-priority instances
// driven side by side against a behavioural arbitration model.
module tb_sram_arbiter;

    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m0_req, m1_req;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [31:0] ram_rdata;

    logic [1:0]    o_m0_gnt, o_m1_gnt, o_m0_rv, o_m1_rv, o_en;
    logic [31:0]   o_m0_rd [2];
    logic [31:0]   o_m1_rd [2];
    logic [31:0]   o_wd [2];
    logic [3:0]    o_we [2];
    logic [AW-1:0] o_addr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_arbiter #(
            .ADDR_W     (AW),
            .FIXED_PRIO (g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_gnt    (o_m0_gnt[g]),
            .m0_rvalid (o_m0_rv[g]),
            .m0_rdata  (o_m0_rd[g]),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_gnt    (o_m1_gnt[g]),
            .m1_rvalid (o_m1_rv[g]),
            .m1_rdata  (o_m1_rd[g]),
            .ram_en    (o_en[g]),
            .ram_we    (o_we[g]),
            .ram_addr  (o_addr[g]),
            .ram_wdata (o_wd[g]),
            .ram_rdata (ram_rdata)
        );
    end

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance (0 = round-robin, 1 = fixed).
    int last_m [2];
    int pend_m [2];
    int nlast  [2];
    int npend  [2];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_check();
        for (int m = 0; m < 2; m++) begin
            int          w;
            logic [3:0]  we;
            logic [31:0] ad, wd, wa;
            logic        rv0, rv1;
            w  = -1;
            we = 4'b0000;
            if (!reset) begin
                if (m0_req && m1_req)
                    w = (m == 1) ? 1 : ((last_m[m] == 0) ? 1 : 0);
                else if (m0_req) w = 0;
                else if (m1_req) w = 1;
            end
            check($sformatf("gnt0[%0d]", m), 32'(o_m0_gnt[m]), 32'(w == 0));
            check($sformatf("gnt1[%0d]", m), 32'(o_m1_gnt[m]), 32'(w == 1));
            check($sformatf("en[%0d]", m), 32'(o_en[m]), 32'(w >= 0));
            if (w >= 0) begin
                we = (w == 1) ? m1_we : m0_we;
                ad = (w == 1) ? m1_addr : m0_addr;
                wd = (w == 1) ? m1_wdata : m0_wdata;
                wa = (ad / 4) % (32'd1 << AW);
                check($sformatf("we[%0d]", m), 32'(o_we[m]), 32'(we));
                check($sformatf("addr[%0d]", m), 32'(o_addr[m]), wa);
                check($sformatf("wdata[%0d]", m), o_wd[m], wd);
            end else begin
                check($sformatf("we_idle[%0d]", m), 32'(o_we[m]), 32'h0);
            end
            rv0 = !reset && (pend_m[m] == 0);
            rv1 = !reset && (pend_m[m] == 1);
            check($sformatf("rv0[%0d]", m), 32'(o_m0_rv[m]), 32'(rv0));
            check($sformatf("rv1[%0d]", m), 32'(o_m1_rv[m]), 32'(rv1));
            check($sformatf("rd0[%0d]", m), o_m0_rd[m], rv0 ? ram_rdata : 32'h0);
            check($sformatf("rd1[%0d]", m), o_m1_rd[m], rv1 ? ram_rdata : 32'h0);
            if (reset) begin
                npend[m] = -1;
                nlast[m] = 1;
            end else begin
                npend[m] = (w >= 0 && we == 4'b0000) ? w : -1;
                nlast[m] = (w >= 0) ? w : last_m[m];
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        last_m = nlast;
        pend_m = npend;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
        ram_rdata = '0;
        last_m = '{1, 1};
        pend_m = '{-1, -1};
        nlast  = '{1, 1};
        npend  = '{-1, -1};

        repeat (2) begin
            m0_req = 1'b1;
            m1_req = 1'b1;
            sample();
            advance();
        end

        // Lone m0 read at byte 0x10.
        reset = 1'b0;
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 4'b0000; m0_addr = 32'h0000_0010;
        sample();
        check("d_rd_addr", 32'(o_addr[0]), 32'h0004);
        check("d_rd_gnt", 32'(o_m0_gnt[0]), 32'h1);
        advance();
        m0_req = 1'b0;
        ram_rdata = 32'h1234_5678;
        sample();
        check("d_rd_rv", 32'(o_m0_rv[0]), 32'h1);
        check("d_rd_data", o_m0_rd[0], 32'h1234_5678);
        advance();

        // m1 partial write.
        m1_req = 1'b1; m1_we = 4'b0011;
        m1_addr = 32'h0000_0104; m1_wdata = 32'hDEAD_BEEF;
        sample();
        check("d_wr_we", 32'(o_we[1]), 32'h3);
        check("d_wr_addr", 32'(o_addr[1]), 32'h0041);
        check("d_wr_data", o_wd[1], 32'hDEAD_BEEF);
        advance();
        m1_req = 1'b0;
        sample();
        check("d_wr_norv", 32'(o_m1_rv[1]), 32'h0);
        advance();

        // Upper address bits wrap.
        m0_req = 1'b1; m0_addr = 32'h0004_0008;
        sample();
        check("d_wrap", 32'(o_addr[0]), 32'h0002);
        advance();
        m0_req = 1'b0;
        sample();
        advance();

        // Read granted, then reset on the following edge.
        m0_req = 1'b1; m0_addr = 32'h0000_0020;
        sample();
        check("d_rst_gnt", 32'(o_m0_gnt[0]), 32'h1);
        advance();
        reset = 1'b1; m0_req = 1'b0;
        sample();
        check("d_rst_rv_rr", 32'(o_m0_rv[0]), 32'h0);
        check("d_rst_rv_fp", 32'(o_m0_rv[1]), 32'h0);
        advance();

        // Both read continuously from reset release.
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 4'b0000;
        m1_req = 1'b1; m1_we = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            ram_rdata = $urandom;
            sample();
            check("rr_alt0", 32'(o_m0_gnt[0]), 32'((i % 2) == 0));
            check("rr_alt1", 32'(o_m1_gnt[0]), 32'((i % 2) == 1));
            check("fp_m1", 32'(o_m1_gnt[1]), 32'h1);
            check("fp_m0", 32'(o_m0_gnt[1]), 32'h0);
            if (i > 0) begin
                check("rr_rv0", 32'(o_m0_rv[0]), 32'((i % 2) == 1));
                check("rr_rv1", 32'(o_m1_rv[0]), 32'((i % 2) == 0));
            end
            advance();
        end

        // Random traffic, including withdrawals and sporadic reset.
        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(0, 63) == 0);
            m0_req   = 1'($urandom_range(0, 1));
            m0_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            m0_addr  = $urandom;
            m0_wdata = $urandom;
            m1_req   = 1'($urandom_range(0, 1));
            m1_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            m1_addr  = $urandom;
            m1_wdata = $urandom;
            ram_rdata = $urandom;
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
